// File: rtl/fir_coef_loader_pkg.sv
// Shared FIR coefficient-path constants and loader state encoding.
// Common widths/depth are also used by fir_filter and the DA block.
package fir_coef_loader_pkg;

    localparam int FIR_DATA_W = 20;
    localparam int FIR_ADDR_W = 11;
    localparam int FIR_DEPTH  = 2048;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_FLUSH = 2'd2
    } loader_state_t;

endpackage

// File: rtl/fir_coef_loader.sv
// Streams coefficient words into the DA LUT memory, addresses 0..DEPTH-1.
// Latency: one cycle from stream acceptance to CIN/CADDR/CLOAD write.
// Backpressure: s_ready only in LOAD without abort; host stalls hold the last write.
module fir_coef_loader
    import fir_coef_loader_pkg::*;
#(
    parameter int DATA_W = FIR_DATA_W,
    parameter int ADDR_W = FIR_ADDR_W,
    parameter int DEPTH  = FIR_DEPTH
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    input  logic              s_last,
    output logic              s_ready,
    output logic [DATA_W-1:0] CIN,
    output logic [ADDR_W-1:0] CADDR,
    output logic              CLOAD,
    output logic              busy,
    output logic              done,
    output logic              err
);

    loader_state_t     state;
    loader_state_t     state_nxt;
    logic [ADDR_W-1:0] k;
    logic              accept;
    logic              k_last;

    assign s_ready = (state == S_LOAD) && !abort;
    assign accept  = s_valid && s_ready;
    assign k_last  = (k == ADDR_W'(DEPTH - 1));

    // Any accepted word flagged last, or the word at the final address, ends the frame.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_LOAD;
            S_LOAD:  if (abort || (accept && (s_last || k_last))) state_nxt = S_FLUSH;
            S_FLUSH: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
            k     <= '0;
            CIN   <= '0;
            CADDR <= '0;
            CLOAD <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        k    <= '0;
                        err  <= 1'b0;
                        busy <= 1'b1;
                    end
                end
                S_LOAD: begin
                    // CLOAD stays high across stalls: rewriting the same word is harmless.
                    if (accept) begin
                        CIN   <= s_data;
                        CADDR <= k;
                        CLOAD <= 1'b1;
                        k     <= k + 1'b1;
                        if (s_last != k_last) err <= 1'b1;
                    end
                    if (abort) err <= 1'b1;
                end
                S_FLUSH: begin
                    CLOAD <= 1'b0;
                    busy  <= 1'b0;
                    done  <= !err;
                end
                default: begin
                    CLOAD <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_coef_loader.sv
// Directed bench for fir_coef_loader with an 8-word frame.
module tb_fir_coef_loader;

    localparam int DW = 20;
    localparam int AW = 11;
    localparam int DP = 8;

    logic          clk = 1'b0;
    logic          resetn;
    logic          start, abort, s_valid, s_last;
    logic [DW-1:0] s_data;
    logic          s_ready, CLOAD, busy, done, err;
    logic [DW-1:0] CIN;
    logic [AW-1:0] CADDR;

    int tests_run    = 0;
    int tests_failed = 0;

    fir_coef_loader #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DP)) dut (
        .clk(clk), .resetn(resetn), .start(start), .abort(abort),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .CIN(CIN), .CADDR(CADDR), .CLOAD(CLOAD), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0; start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
        step(); step();
        tests_run++; if ({CLOAD, busy, done, err} !== 4'b0) begin tests_failed++; $display("FAIL reset_flags: got %b want 0000", {CLOAD, busy, done, err}); end
        tests_run++; if (s_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ready: got %b want 0", s_ready); end
        resetn = 1'b1;
        step();
        do_start();
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1; s_data = 20'h00010 + 20'(i); s_last = 1'b0;
            step();
        end
        tests_run++; if (CADDR !== 11'd3 || CLOAD !== 1'b1) begin tests_failed++; $display("FAIL reset_preload: got caddr=%0h cload=%b want 3 1", CADDR, CLOAD); end
        s_data = 20'h00014;
        #2 resetn = 1'b0;
        #1;
        tests_run++; if ({CLOAD, busy} !== 2'b00) begin tests_failed++; $display("FAIL reset_mid_flags: got %b want 00", {CLOAD, busy}); end
        tests_run++; if (CADDR !== 11'd0 || CIN !== 20'd0) begin tests_failed++; $display("FAIL reset_mid_data: got caddr=%0h cin=%0h want 0 0", CADDR, CIN); end
        s_valid = 1'b0;
        step();
        resetn = 1'b1;
        step();
        tests_run++; if (s_ready !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL reset_idle: got ready=%b busy=%b want 0 0", s_ready, busy); end
    endtask

    task automatic test_full_load();
        do_start();
        tests_run++; if (busy !== 1'b1 || CLOAD !== 1'b0) begin tests_failed++; $display("FAIL full_enter: got busy=%b cload=%b want 1 0", busy, CLOAD); end
        for (int i = 0; i < DP; i++) begin
            s_valid = 1'b1; s_data = 20'h00010 + 20'(i); s_last = (i == DP - 1);
            #1;
            tests_run++; if (s_ready !== 1'b1) begin tests_failed++; $display("FAIL full_ready[%0d]: got %b want 1", i, s_ready); end
            step();
            tests_run++; if (CLOAD !== 1'b1 || CADDR !== 11'(i) || CIN !== 20'h00010 + 20'(i))
                begin tests_failed++; $display("FAIL full_write[%0d]: got cload=%b caddr=%0h cin=%0h want 1 %0h %0h", i, CLOAD, CADDR, CIN, i, 20'h00010 + 20'(i)); end
            tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL full_early_done[%0d]: got %b want 0", i, done); end
        end
        s_valid = 1'b0; s_last = 1'b0;
        step();
        tests_run++; if ({CLOAD, busy, done, err} !== 4'b0010) begin tests_failed++; $display("FAIL full_end: got cload,busy,done,err=%b want 0010", {CLOAD, busy, done, err}); end
        step();
        tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL full_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_gaps();
        do_start();
        for (int i = 0; i < DP; i++) begin
            s_valid = 1'b1; s_data = 20'h00010 + 20'(i); s_last = (i == DP - 1);
            step();
            tests_run++; if (CLOAD !== 1'b1 || CADDR !== 11'(i) || CIN !== 20'h00010 + 20'(i))
                begin tests_failed++; $display("FAIL gap_write[%0d]: got cload=%b caddr=%0h cin=%0h want 1 %0h %0h", i, CLOAD, CADDR, CIN, i, 20'h00010 + 20'(i)); end
            if (i == 2) begin
                s_valid = 1'b0;
                for (int g = 0; g < 3; g++) begin
                    step();
                    tests_run++; if (CLOAD !== 1'b1 || CADDR !== 11'd2 || CIN !== 20'h00012)
                        begin tests_failed++; $display("FAIL gap_hold[%0d]: got cload=%b caddr=%0h cin=%0h want 1 2 12", g, CLOAD, CADDR, CIN); end
                end
            end
        end
        s_valid = 1'b0; s_last = 1'b0;
        step();
        tests_run++; if ({CLOAD, busy, done, err} !== 4'b0010) begin tests_failed++; $display("FAIL gap_end: got %b want 0010", {CLOAD, busy, done, err}); end
    endtask

    task automatic test_early_last();
        do_start();
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1; s_data = 20'h00010 + 20'(i); s_last = (i == 3);
            step();
        end
        s_valid = 1'b0; s_last = 1'b0;
        tests_run++; if (CLOAD !== 1'b1 || CADDR !== 11'd3 || err !== 1'b1) begin tests_failed++; $display("FAIL early_flush: got cload=%b caddr=%0h err=%b want 1 3 1", CLOAD, CADDR, err); end
        step();
        tests_run++; if ({CLOAD, busy, done, err} !== 4'b0001) begin tests_failed++; $display("FAIL early_end: got %b want 0001", {CLOAD, busy, done, err}); end
        step();
        tests_run++; if (done !== 1'b0 || err !== 1'b1) begin tests_failed++; $display("FAIL early_sticky: got done=%b err=%b want 0 1", done, err); end
    endtask

    task automatic test_late_last();
        do_start();
        for (int i = 0; i < DP; i++) begin
            s_valid = 1'b1; s_data = 20'h00010 + 20'(i); s_last = 1'b0;
            step();
        end
        s_valid = 1'b0;
        tests_run++; if (CLOAD !== 1'b1 || CADDR !== 11'd7 || err !== 1'b1) begin tests_failed++; $display("FAIL late_flush: got cload=%b caddr=%0h err=%b want 1 7 1", CLOAD, CADDR, err); end
        step();
        tests_run++; if ({CLOAD, busy, done, err} !== 4'b0001) begin tests_failed++; $display("FAIL late_end: got %b want 0001", {CLOAD, busy, done, err}); end
        do_start();
        tests_run++; if (err !== 1'b0 || busy !== 1'b1) begin tests_failed++; $display("FAIL late_restart: got err=%b busy=%b want 0 1", err, busy); end
        for (int i = 0; i < DP; i++) begin
            s_valid = 1'b1; s_data = 20'h00020 + 20'(i); s_last = (i == DP - 1);
            step();
        end
        s_valid = 1'b0; s_last = 1'b0;
        tests_run++; if (CADDR !== 11'd7 || CIN !== 20'h00027) begin tests_failed++; $display("FAIL late_reload: got caddr=%0h cin=%0h want 7 27", CADDR, CIN); end
        step();
        tests_run++; if ({CLOAD, busy, done, err} !== 4'b0010) begin tests_failed++; $display("FAIL late_reload_end: got %b want 0010", {CLOAD, busy, done, err}); end
    endtask

    task automatic test_abort();
        do_start();
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1; s_data = 20'h00010 + 20'(i); s_last = 1'b0;
            start = (i == 2);
            step();
            tests_run++; if (CADDR !== 11'(i) || err !== 1'b0) begin tests_failed++; $display("FAIL abort_pre[%0d]: got caddr=%0h err=%b want %0h 0", i, CADDR, err, i); end
        end
        start = 1'b0;
        s_data = 20'h00015; abort = 1'b1;
        #1;
        tests_run++; if (s_ready !== 1'b0) begin tests_failed++; $display("FAIL abort_ready: got %b want 0", s_ready); end
        step();
        abort = 1'b0; s_valid = 1'b0;
        tests_run++; if (CLOAD !== 1'b1 || CADDR !== 11'd4 || CIN !== 20'h00014 || err !== 1'b1)
            begin tests_failed++; $display("FAIL abort_flush: got cload=%b caddr=%0h cin=%0h err=%b want 1 4 14 1", CLOAD, CADDR, CIN, err); end
        start = 1'b1;
        step();
        start = 1'b0;
        tests_run++; if ({CLOAD, busy, done, err} !== 4'b0001) begin tests_failed++; $display("FAIL abort_end: got %b want 0001", {CLOAD, busy, done, err}); end
        step();
        tests_run++; if (busy !== 1'b0 || s_ready !== 1'b0) begin tests_failed++; $display("FAIL abort_start_ignored: got busy=%b ready=%b want 0 0", busy, s_ready); end
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_gaps();
        test_early_last();
        test_late_last();
        test_abort();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fir_coef_loader.md
Name: fir_coef_loader

Overview:
- Writer side of the filter's coefficient-load interface. Drives CIN/CADDR/CLOAD into the DA LUT memory from a ready/valid coefficient stream supplied by a host or a ROM sequencer.
- Walks addresses 0..DEPTH-1 in order and checks framing with s_last.
- Reports completion or error, and exposes busy so Control can hold off valid_in while a load is in progress.
- Runs on the clock that feeds the DA (clk_fast domain).

Parameters:
- DATA_W, 20, coefficient word width; matches CIN.
- ADDR_W, 11, address width; matches CADDR.
- DEPTH, 2048, number of words per full load; must be ≤ 2^ADDR_W and ≥ 2.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to begin a load; ignored unless IDLE.
- abort  in  1  terminate the load in progress.
- s_data  in  DATA_W  coefficient word.
- s_valid  in  1  s_data is valid.
- s_last  in  1  marks the final word of the frame.
- s_ready  out  1  loader accepts a word this cycle.
- CIN  out  DATA_W  coefficient to DA memory.
- CADDR  out  ADDR_W  DA memory address.
- CLOAD  out  1  DA write enable (level).
- busy  out  1  load in progress.
- done  out  1  single-cycle pulse on a successful load.
- err  out  1  sticky error flag; cleared by start.

Behaviour:
- Reset (asynchronous, resetn=0): state=IDLE; CIN=0, CADDR=0, CLOAD=0, busy=0, done=0, err=0, and the internal address counter k=0. Outputs go to these values immediately, including in the middle of a load. No partial-load recovery is provided; the host restarts.
- FSM states: IDLE, LOAD, FLUSH.
- IDLE:
  - start=1 moves to LOAD next cycle, with k=0 and err=0.
  - busy=1 from that next cycle onward.
- LOAD:
  - s_ready = (state==LOAD) && !abort. This is combinational.
  - A word is accepted when s_valid && s_ready.
  - On acceptance, the next cycle shows CIN=s_data, CADDR=k, CLOAD=1, and k increments. Latency from acceptance to write is one cycle.
  - While no word is accepted, CIN and CADDR hold their last values and CLOAD stays 1 once the first word has been accepted. The DA rewrites the same address with the same data, which is idempotent. CLOAD stays 0 before the first acceptance.
  - A word is accepted with k==DEPTH-1 and s_last=1: go to FLUSH (normal end).
  - A word is accepted with s_last != (k==DEPTH-1): framing error. Set err=1 and go to FLUSH. The offending word is still written.
  - abort=1: no acceptance that cycle; set err=1 and go to FLUSH.
- FLUSH (exactly one cycle):
  - CLOAD is still 1, so the final registered word is written.
  - Next cycle: state=IDLE, CLOAD=0, busy=0.
  - done=1 in that same cycle only if err=0.
- Cycle example, continuous s_valid, start at cycle 0:
  - LOAD from cycle 1; words accepted on cycles 1..DEPTH.
  - CLOAD=1 on cycles 2..DEPTH+1; CADDR = cycle−2.
  - done=1 and busy=0 at cycle DEPTH+2.
- Other rules:
  - start while busy is ignored.
  - abort in IDLE or FLUSH is ignored.
  - CADDR never wraps inside one load; k is reset at each start.
  - Addresses are written strictly ascending with no skips.

Decomposition:
- Shared header/package holds:
  - the state encodings (IDLE=2'd0, LOAD=2'd1, FLUSH=2'd2);
  - the default DATA_W/ADDR_W/DEPTH constants, which are shared with fir_filter and da.
- Single flat module. The FSM, the counter and the output registers are small, so no sub-module is needed.

Test Plan (DEPTH=8 for benches):
- Reset: resetn low mid-load at k=4 → CLOAD, busy, CADDR and CIN go to 0 immediately; after release, state is IDLE and s_ready=0.
- Full load: start, then s_data=20'h00010+i with continuous s_valid and s_last on i=7 → CADDR 0..7 on 8 consecutive cycles with CIN matching; CLOAD high exactly 8 cycles; done=1 for 1 cycle right after; err=0.
- Gaps: s_valid low for 3 cycles after i=2 → CADDR=2 and CIN=20'h00012 held, CLOAD stays 1, the next write is CADDR=3; no address skipped or duplicated out of order.
- Early last: s_last on i=3 → err=1, CLOAD drops 2 cycles after acceptance, done never pulses, busy=0.
- Late/missing last: no s_last on i=7 → err=1, same termination; a subsequent start clears err and a good load passes.
- Abort: abort asserted with s_valid at i=5 → s_ready=0 that cycle, word 5 not written, err=1, CLOAD deasserts 2 cycles later; start pulses while busy are ignored.
